// File: rtl/uart_pkg.sv
// Shared types for the UART baud-rate configuration controller.
//   baud_state_e     : controller sequencing states
//   baud_cfg_t       : one complete baud generator setting (x1 and x16 paths)
//   BAUD_CFG_DEFAULT : power-on baud setting
//   cfg_ok()         : a setting is usable only if neither divisor is zero
package uart_pkg;

  localparam int unsigned UART_DIV_W = 16;
  localparam int unsigned UART_FRA_W = 4;

  typedef enum logic [2:0] {
    STATE_RESET   = 3'd0,
    STATE_STOPPED = 3'd1,
    STATE_RUN     = 3'd2,
    STATE_DRAIN   = 3'd3,
    STATE_SWITCH  = 3'd4
  } baud_state_e;

  typedef struct packed {
    logic [UART_DIV_W-1:0] divisor;
    logic [UART_FRA_W-1:0] fra_adj;
    logic [UART_DIV_W-1:0] divisor_x16;
    logic [UART_FRA_W-1:0] fra_adj_x16;
  } baud_cfg_t;

  localparam baud_cfg_t BAUD_CFG_DEFAULT = '{
    divisor:     16'd434,
    fra_adj:     4'd0,
    divisor_x16: 16'd27,
    fra_adj_x16: 4'd8
  };

  // A zero divisor would stall the baud generator, so it is never applied.
  function automatic logic cfg_ok(input baud_cfg_t cfg);
    return (cfg.divisor != '0) && (cfg.divisor_x16 != '0);
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_timer.sv
// Loadable down-counter shared by the reset/switch hold and the drain timeout.
//   clk, rst  : clock, synchronous active-high reset (count reloads RST_VAL)
//   load      : load count from load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   count     : current count
module uart_baud_ctrl_timer
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RST_VAL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= WIDTH'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud generator configuration and sequencing controller.
// Accepts new divisor settings over a valid/ready handshake, waits for the
// TX/RX engines to go idle (or a drain timeout), then applies the setting
// through a clean disable / reset / re-enable sequence of the baud generator.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_enable                : global baud enable request
//   i_cfg_valid/o_cfg_ready : configuration handshake
//   i_cfg_*                 : requested divisors / fractional adjusts
//   i_tx_busy, i_rx_busy    : engines mid-frame
//   o_divisor..o_fra_adj_x16: applied settings
//   o_baud_en, o_baud_x16_en: tick enables
//   o_baudgen_rstn          : active-low baud generator reset
//   o_cfg_done, o_cfg_err   : one-cycle applied / rejected pulses
//   o_drain_timeout         : sticky, last switch was forced by timeout
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = UART_DIV_W,
  parameter int unsigned FRA_WIDTH       = UART_FRA_W,
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned DRAIN_TIMEOUT   = 65535,
  parameter int unsigned DEF_DIVISOR     = 434,
  parameter int unsigned DEF_DIVISOR_X16 = 27,
  parameter int unsigned DEF_FRA_ADJ_X16 = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [DIV_WIDTH-1:0] i_cfg_divisor,
  input  logic [FRA_WIDTH-1:0] i_cfg_fra_adj,
  input  logic [DIV_WIDTH-1:0] i_cfg_divisor_x16,
  input  logic [FRA_WIDTH-1:0] i_cfg_fra_adj_x16,
  input  logic                 i_tx_busy,
  input  logic                 i_rx_busy,
  output logic [DIV_WIDTH-1:0] o_divisor,
  output logic [FRA_WIDTH-1:0] o_fra_adj,
  output logic [DIV_WIDTH-1:0] o_divisor_x16,
  output logic [FRA_WIDTH-1:0] o_fra_adj_x16,
  output logic                 o_baud_en,
  output logic                 o_baud_x16_en,
  output logic                 o_baudgen_rstn,
  output logic                 o_cfg_done,
  output logic                 o_cfg_err,
  output logic                 o_drain_timeout
);

  localparam logic [2:0] ST_RESET   = 3'(STATE_RESET);
  localparam logic [2:0] ST_STOPPED = 3'(STATE_STOPPED);
  localparam logic [2:0] ST_RUN     = 3'(STATE_RUN);
  localparam logic [2:0] ST_DRAIN   = 3'(STATE_DRAIN);
  localparam logic [2:0] ST_SWITCH  = 3'(STATE_SWITCH);

  localparam int unsigned TMR_MAX = (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam baud_cfg_t CFG_RESET = '{
    divisor:     UART_DIV_W'(DEF_DIVISOR),
    fra_adj:     '0,
    divisor_x16: UART_DIV_W'(DEF_DIVISOR_X16),
    fra_adj_x16: UART_FRA_W'(DEF_FRA_ADJ_X16)
  };

  logic [2:0]       state_q, state_d;
  baud_cfg_t        cfg_in, shadow_q, shadow_d, applied_q, applied_d;
  logic             cfg_accept, cfg_reject;
  logic             tmr_load, tmr_dec, tmr_last;
  logic [TMR_W-1:0] tmr_val, tmr_cnt;
  logic             ready_d, en_d, rstn_d, done_d, err_d, tmo_d;

  assign cfg_in = '{
    divisor:     UART_DIV_W'(i_cfg_divisor),
    fra_adj:     UART_FRA_W'(i_cfg_fra_adj),
    divisor_x16: UART_DIV_W'(i_cfg_divisor_x16),
    fra_adj_x16: UART_FRA_W'(i_cfg_fra_adj_x16)
  };

  // o_cfg_ready is only high in STOPPED/RUN, so valid is ignored elsewhere.
  assign cfg_accept = i_cfg_valid && o_cfg_ready && cfg_ok(cfg_in);
  assign cfg_reject = i_cfg_valid && o_cfg_ready && !cfg_ok(cfg_in);
  assign tmr_last   = (tmr_cnt <= TMR_W'(1));

  // Shared hold / drain-timeout counter.
  uart_baud_ctrl_timer #(
    .WIDTH   (TMR_W),
    .RST_VAL (RST_CYCLES)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_cnt)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    applied_d = applied_q;
    tmr_load  = 1'b0;
    tmr_val   = TMR_W'(RST_CYCLES);
    tmr_dec   = 1'b0;
    done_d    = 1'b0;
    err_d     = cfg_reject;
    tmo_d     = o_drain_timeout;

    if (cfg_accept) begin
      tmo_d = 1'b0;
    end

    case (state_q)
      ST_RESET: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          state_d = i_enable ? ST_RUN : ST_STOPPED;
        end
      end
      ST_STOPPED: begin
        if (cfg_accept) begin
          shadow_d = cfg_in;
          state_d  = ST_SWITCH;
        end else if (i_enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_accept) begin
          shadow_d = cfg_in;
          state_d  = ST_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(DRAIN_TIMEOUT);
        end else if (!i_enable) begin
          state_d = ST_STOPPED;
        end
      end
      ST_DRAIN: begin
        // A zero timeout means wait for idle indefinitely.
        tmr_dec = (DRAIN_TIMEOUT != 0);
        if (!i_enable || (!i_tx_busy && !i_rx_busy)) begin
          state_d = ST_SWITCH;
        end else if ((DRAIN_TIMEOUT != 0) && tmr_last) begin
          state_d = ST_SWITCH;
          tmo_d   = 1'b1;
        end
      end
      ST_SWITCH: begin
        tmr_dec = 1'b1;
        if (tmr_last) begin
          done_d  = 1'b1;
          state_d = i_enable ? ST_RUN : ST_STOPPED;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Applied settings move only on SWITCH entry, while enables are already low.
    if ((state_d == ST_SWITCH) && (state_q != ST_SWITCH)) begin
      applied_d = shadow_d;
      tmr_load  = 1'b1;
      tmr_val   = TMR_W'(RST_CYCLES);
    end

    ready_d = (state_d == ST_STOPPED) || (state_d == ST_RUN);
    en_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    rstn_d  = (state_d != ST_RESET) && (state_d != ST_SWITCH);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= ST_RESET;
      shadow_q        <= CFG_RESET;
      applied_q       <= CFG_RESET;
      o_cfg_ready     <= 1'b0;
      o_baud_en       <= 1'b0;
      o_baud_x16_en   <= 1'b0;
      o_baudgen_rstn  <= 1'b0;
      o_cfg_done      <= 1'b0;
      o_cfg_err       <= 1'b0;
      o_drain_timeout <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_q        <= shadow_d;
      applied_q       <= applied_d;
      o_cfg_ready     <= ready_d;
      o_baud_en       <= en_d;
      o_baud_x16_en   <= en_d;
      o_baudgen_rstn  <= rstn_d;
      o_cfg_done      <= done_d;
      o_cfg_err       <= err_d;
      o_drain_timeout <= tmo_d;
    end
  end

  assign o_divisor     = DIV_WIDTH'(applied_q.divisor);
  assign o_fra_adj     = FRA_WIDTH'(applied_q.fra_adj);
  assign o_divisor_x16 = DIV_WIDTH'(applied_q.divisor_x16);
  assign o_fra_adj_x16 = FRA_WIDTH'(applied_q.fra_adj_x16);

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl. Every offered configuration pushes
// its expected o_cfg_done / o_cfg_err event (cycle, applied values, timeout
// flag) onto a scoreboard queue; a negedge monitor pops and compares events.
module tb_uart_baud_ctrl;

  localparam int unsigned RST_CYC = 4;
  localparam int unsigned TMO     = 50;
  localparam int unsigned HOLD    = 40;

  logic        i_clk = 1'b0;
  logic        i_rst, i_enable, i_cfg_valid, o_cfg_ready;
  logic [15:0] i_cfg_divisor, i_cfg_divisor_x16;
  logic [3:0]  i_cfg_fra_adj, i_cfg_fra_adj_x16;
  logic        i_tx_busy, i_rx_busy;
  logic [15:0] o_divisor, o_divisor_x16;
  logic [3:0]  o_fra_adj, o_fra_adj_x16;
  logic        o_baud_en, o_baud_x16_en, o_baudgen_rstn;
  logic        o_cfg_done, o_cfg_err, o_drain_timeout;

  always #5 i_clk = ~i_clk;

  uart_baud_ctrl #(
    .DIV_WIDTH       (16),
    .FRA_WIDTH       (4),
    .RST_CYCLES      (RST_CYC),
    .DRAIN_TIMEOUT   (TMO),
    .DEF_DIVISOR     (434),
    .DEF_DIVISOR_X16 (27),
    .DEF_FRA_ADJ_X16 (8)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_enable          (i_enable),
    .i_cfg_valid       (i_cfg_valid),
    .o_cfg_ready       (o_cfg_ready),
    .i_cfg_divisor     (i_cfg_divisor),
    .i_cfg_fra_adj     (i_cfg_fra_adj),
    .i_cfg_divisor_x16 (i_cfg_divisor_x16),
    .i_cfg_fra_adj_x16 (i_cfg_fra_adj_x16),
    .i_tx_busy         (i_tx_busy),
    .i_rx_busy         (i_rx_busy),
    .o_divisor         (o_divisor),
    .o_fra_adj         (o_fra_adj),
    .o_divisor_x16     (o_divisor_x16),
    .o_fra_adj_x16     (o_fra_adj_x16),
    .o_baud_en         (o_baud_en),
    .o_baud_x16_en     (o_baud_x16_en),
    .o_baudgen_rstn    (o_baudgen_rstn),
    .o_cfg_done        (o_cfg_done),
    .o_cfg_err         (o_cfg_err),
    .o_drain_timeout   (o_drain_timeout)
  );

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] div;
    logic [3:0]  fra;
    logic [15:0] div16;
    logic [3:0]  fra16;
    bit          tmo;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Expected applied settings.
  logic [15:0] m_div, m_div16;
  logic [3:0]  m_fra, m_fra16;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event monitor plus the "applied settings never move while enabled" rule.
  logic [39:0] prev_app;
  bit          have_prev = 1'b0;
  exp_t        ev;
  always @(negedge i_clk) begin
    if (have_prev && ({o_divisor, o_fra_adj, o_divisor_x16, o_fra_adj_x16} != prev_app))
      chk("apply_while_en", 32'(o_baud_en | o_baud_x16_en), 32'd0);
    prev_app  = {o_divisor, o_fra_adj, o_divisor_x16, o_fra_adj_x16};
    have_prev = 1'b1;
    if (o_cfg_done || o_cfg_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", {30'd0, o_cfg_done, o_cfg_err}, 32'd0);
      end else begin
        ev = sb.pop_front();
        chk("evt_done", 32'(o_cfg_done), 32'(!ev.is_err));
        chk("evt_err", 32'(o_cfg_err), 32'(ev.is_err));
        chk("evt_cycle", 32'(cyc), 32'(ev.due));
        chk("evt_div", 32'(o_divisor), 32'(ev.div));
        chk("evt_fra", 32'(o_fra_adj), 32'(ev.fra));
        chk("evt_div16", 32'(o_divisor_x16), 32'(ev.div16));
        chk("evt_fra16", 32'(o_fra_adj_x16), 32'(ev.fra16));
        chk("evt_tmo", 32'(o_drain_timeout), 32'(ev.tmo));
      end
    end
  end

  // Offer one config for one clock; lat < 0 means no completion event is expected.
  task automatic offer(input logic [15:0] d, input logic [3:0] f, input logic [15:0] d16,
                       input logic [3:0] f16, input int lat, input bit tmo);
    exp_t e;
    i_cfg_divisor     = d;
    i_cfg_fra_adj     = f;
    i_cfg_divisor_x16 = d16;
    i_cfg_fra_adj_x16 = f16;
    i_cfg_valid       = 1'b1;
    @(posedge i_clk);
    #1;
    i_cfg_valid = 1'b0;
    if (lat >= 0) begin
      e.is_err = (d == 16'd0) || (d16 == 16'd0);
      e.tmo    = tmo;
      if (e.is_err) begin
        e.div = m_div; e.fra = m_fra; e.div16 = m_div16; e.fra16 = m_fra16;
        e.due = cyc;
      end else begin
        e.div = d; e.fra = f; e.div16 = d16; e.fra16 = f16;
        e.due = cyc + lat;
        m_div = d; m_fra = f; m_div16 = d16; m_fra16 = f16;
      end
      sb.push_back(e);
    end
  endtask

  // Hold reset for some edges, check defaults, then measure the RESET hold length.
  task automatic do_reset(input int edges);
    int n;
    i_rst = 1'b1;
    repeat (edges) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    m_div = 16'd434; m_fra = 4'd0; m_div16 = 16'd27; m_fra16 = 4'd8;
    @(negedge i_clk);
    chk("rst_rstn", 32'(o_baudgen_rstn), 32'd0);
    chk("rst_en", 32'(o_baud_en), 32'd0);
    chk("rst_en16", 32'(o_baud_x16_en), 32'd0);
    chk("rst_ready", 32'(o_cfg_ready), 32'd0);
    chk("rst_div", 32'(o_divisor), 32'd434);
    chk("rst_fra", 32'(o_fra_adj), 32'd0);
    chk("rst_div16", 32'(o_divisor_x16), 32'd27);
    chk("rst_fra16", 32'(o_fra_adj_x16), 32'd8);
    chk("rst_flags", {29'd0, o_cfg_done, o_cfg_err, o_drain_timeout}, 32'd0);
    n = 0;
    while (o_baudgen_rstn == 1'b0 && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    chk("rst_len", 32'(n), 32'(RST_CYC));
    chk("run_en", 32'(o_baud_en), 32'd1);
    chk("run_en16", 32'(o_baud_x16_en), 32'd1);
    chk("run_ready", 32'(o_cfg_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1; i_enable = 1'b1; i_cfg_valid = 1'b0;
    i_cfg_divisor = '0; i_cfg_fra_adj = '0; i_cfg_divisor_x16 = '0; i_cfg_fra_adj_x16 = '0;
    i_tx_busy = 1'b0; i_rx_busy = 1'b0;

    do_reset(3);

    // RUN, engines idle: one DRAIN cycle then the switch hold.
    offer(16'd868, 4'd0, 16'd54, 4'd4, 1 + RST_CYC, 1'b0);
    @(negedge i_clk);
    chk("drain_en", 32'(o_baud_en), 32'd1);
    chk("drain_ready", 32'(o_cfg_ready), 32'd0);
    @(negedge i_clk);
    chk("switch_en", 32'(o_baud_en | o_baud_x16_en), 32'd0);
    chk("switch_rstn", 32'(o_baudgen_rstn), 32'd0);
    chk("switch_div", 32'(o_divisor), 32'd868);
    repeat (6) @(posedge i_clk);
    #1;

    // TX busy holds off the switch; old settings and enables stay.
    i_tx_busy = 1'b1;
    offer(16'd217, 4'd0, 16'd13, 4'd9, HOLD + 1 + RST_CYC, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      @(negedge i_clk);
      chk("busy_en", 32'(o_baud_en), 32'd1);
      chk("busy_old_div", 32'(o_divisor), 32'd868);
    end
    @(posedge i_clk);
    #1;
    i_tx_busy = 1'b0;
    @(negedge i_clk);
    chk("busy_fall_en", 32'(o_baud_en), 32'd1);
    @(negedge i_clk);
    chk("busy_switch_en", 32'(o_baud_en), 32'd0);
    repeat (6) @(posedge i_clk);
    #1;

    // Zero divisors are rejected; nothing else moves.
    offer(16'd500, 4'd0, 16'd0, 4'd3, 0, 1'b0);
    @(negedge i_clk);
    chk("err_ready", 32'(o_cfg_ready), 32'd1);
    chk("err_en", 32'(o_baud_en), 32'd1);
    offer(16'd0, 4'd1, 16'd20, 4'd1, 0, 1'b0);
    repeat (4) @(posedge i_clk);
    #1;

    // RX stuck busy: forced switch after the drain timeout, sticky flag.
    i_rx_busy = 1'b1;
    offer(16'd300, 4'd2, 16'd19, 4'd5, TMO + RST_CYC, 1'b1);
    repeat (TMO + RST_CYC + 4) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("tmo_sticky", 32'(o_drain_timeout), 32'd1);
    i_rx_busy = 1'b0;
    offer(16'd868, 4'd0, 16'd54, 4'd4, 1 + RST_CYC, 1'b0);
    @(negedge i_clk);
    chk("tmo_cleared", 32'(o_drain_timeout), 32'd0);
    repeat (8) @(posedge i_clk);
    #1;

    // STOPPED: config goes straight to SWITCH, enables stay low afterwards.
    i_enable = 1'b0;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("stop_en", 32'(o_baud_en), 32'd0);
    chk("stop_ready", 32'(o_cfg_ready), 32'd1);
    chk("stop_rstn", 32'(o_baudgen_rstn), 32'd1);
    offer(16'd1302, 4'd3, 16'd81, 4'd6, RST_CYC, 1'b0);
    repeat (RST_CYC + 2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("stop_stays_off", 32'(o_baud_en), 32'd0);
    i_enable = 1'b1;
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("restart_en", 32'(o_baud_en), 32'd1);

    // Reset in the middle of SWITCH: defaults back, no completion pulse.
    offer(16'd1000, 4'd1, 16'd60, 4'd2, -1, 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    do_reset(1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge i_clk);
      n++;
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    repeat (10) @(posedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
